keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart of the scanned 4-digit 7-seg driver. Drives a 4x4 hex keypad by row
//  scanning, reads columns, debounces per scan frame and emits one-shot key events.
//  Accepted keys shift into a 16-bit hex-digit register that feeds the display driver's
//  digits input directly.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles each row is driven (min 4; >= COL sync depth + 2)
//  DEBOUNCE_CNT  4      consecutive identical frames needed to accept a press or a release (1..15)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous active-low reset (0 = reset)
//  ROW        out  4   row drive, active-low one-cold; ROW[r]=0 while row r is scanned
//  COL        in   4   column sense, active-low (pulled up), asynchronous to clk
//  clr        in   1   synchronous clear of digits
//  key_valid  out  1   one-cycle pulse on each accepted press
//  key_code   out  4   code of last accepted key, {row[1:0],col[1:0]}; held between presses
//  key_held   out  1   1 from accepted press until accepted release
//  digits     out 16   hex entry register; new code enters [3:0], older digits shift up
// BEHAVIOUR
//  - Reset: ROW=4'b1110 (row 0), key_valid=0, key_code=0, key_held=0, digits=0,
//    row/div counters=0, debounce count=0, candidate=NONE.
//  - COL passes a 2-FF synchronizer before any use.
//  - Scan: div counter runs 0..SCAN_DIV-1; at SCAN_DIV-1 sample synced COL for the current row,
//    then advance row 0->1->2->3->0, ROW updating on the same edge. Frame = 4*SCAN_DIV cycles.
//  - Frame result, evaluated on the cycle the row-3 sample is taken:
//    NONE = no column low in any row; KEY(c) = exactly one low bit in total, c={r,col};
//    MULTI = two or more low bits (ghosting / chords).
//  - Debounce: if result == candidate, count += 1 (saturates at DEBOUNCE_CNT); otherwise
//    candidate = result and count = 1. A MULTI frame sets candidate=MULTI and never qualifies.
//  - Press: the count reaches DEBOUNCE_CNT with candidate=KEY(c) and key_held=0.
//    Next cycle: key_valid=1 (one cycle), key_code=c, key_held=1, digits={digits[11:0],c}.
//  - Release: the count reaches DEBOUNCE_CNT with candidate=NONE and key_held=1. Next cycle:
//    key_held=0. No pulse.
//  - While key_held=1, a different stable KEY or MULTI is ignored. A new press is reported
//    only after a confirmed release (no rollover).
//  - Latency, key pressed before frame k starts: key_valid fires 1 cycle after the end of
//    frame k+DEBOUNCE_CNT-1.
//  - clr=1: digits=0 next cycle. clr and a press in the same cycle: digits={12'h000,c}.
//    key_code and key_held are unaffected by clr.
//  - rst asserted mid-scan or mid-debounce: all state returns to reset values immediately.
//    There is no pending-event memory.
//  - digits wraps: the oldest nibble [15:12] is discarded on each press.
// STRUCTURE
//  - Shared package keypad_pkg: ROWS=4, COLS=4, CODE_W=4, frame-result encoding
//    (NONE, KEY, MULTI), default timing constants.
//  - One sub-module, keypad_debounce: frame result in, candidate/count logic, press/release
//    strobes out.
//  - The top holds the synchronizer, scan counters, frame decode and the digits shift
//    register. No FSM beyond the row counter; the debouncer is a 2-state held/released machine.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=3; keypad model pulls COL[c] low when ROW[r]=0 and key
//          (r,c) is closed)
//  - Reset / scan: release rst -> ROW cycles 1110,1101,1011,0111 every 4 clk; all outputs 0.
//  - Single press: hold key (2,1) for 5 frames -> exactly one key_valid; key_code=4'h9;
//    digits=16'h0009; key_held=1.
//    Open the key -> key_held=0 after 3 clean frames.
//  - Sequence: press and release 1, 2, 3, 4, 5 -> digits=16'h2345, exactly five pulses.
//  - Bounce: toggle the key every frame for 4 frames, then hold -> one pulse, only after
//    3 stable frames. Key closed for 2 frames only -> no pulse.
//  - Chord / no rollover: keys 0 and 5 closed together -> no pulse. Hold 7, then add 8,
//    then drop 7 -> only the 7 event, until a full release.
//  - clr and reset: clr in the press cycle of key A -> digits=16'h000A. Assert rst in the
//    middle of the 2nd debounce frame -> no pulse, all outputs 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared geometry, timing defaults and frame-result types for the keypad scanner
package keypad_pkg;

    localparam int ROWS         = 4;
    localparam int COLS         = 4;
    localparam int CODE_W       = 4;
    localparam int SCAN_DIV_DEF = 50000;
    localparam int DEBOUNCE_DEF = 4;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_KEY,
        RES_MULTI
    } res_kind_t;

    typedef struct packed {
        res_kind_t         kind;
        logic [CODE_W-1:0] code;
    } frame_res_t;

    function automatic logic [1:0] col_index(input logic [COLS-1:0] low);
        return low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
    endfunction

    // Low-bit tally that saturates at 2: anything beyond one key is just MULTI.
    function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level candidate/count debouncer with held/released press tracking
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  frame_res_t        res,
    output logic              press,
    output logic              rel,
    output logic [CODE_W-1:0] code
);

    localparam logic [3:0] LIMIT = 4'(DEBOUNCE_CNT);

    typedef enum logic {
        RELEASED,
        HELD
    } db_state_t;

    db_state_t  state, state_next;
    frame_res_t cand;
    logic [3:0] cnt, cnt_next;
    logic       same, stable;

    always_comb begin
        same       = res.kind == cand.kind && (res.kind != RES_KEY || res.code == cand.code);
        cnt_next   = !same ? 4'd1 : (cnt == LIMIT) ? cnt : cnt + 4'd1;
        stable     = frame_valid && cnt_next == LIMIT;
        press      = stable && state == RELEASED && res.kind == RES_KEY;
        rel        = stable && state == HELD && res.kind == RES_NONE;
        state_next = press ? HELD : rel ? RELEASED : state;
    end

    assign code = res.code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RELEASED;
            cand  <= '{kind: RES_NONE, code: '0};
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (frame_valid) begin
                cand <= res;
                cnt  <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 row-scanned keypad reader feeding a 4-digit hex entry register
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   ROW,
    input  logic [COLS-1:0]   COL,
    input  logic              clr,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic [15:0]       digits
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [COLS-1:0]   col_s1, col_s2, low;
    logic [DIV_W-1:0]  div;
    logic [1:0]        row, acc_n, row_n, total;
    logic [CODE_W-1:0] acc_code, row_code, db_code;
    logic              sample, frame_valid, press, rel;
    frame_res_t        res;

    assign low         = ~col_s2;
    assign sample      = div == DIV_LAST;
    assign frame_valid = sample && row == 2'd3;
    assign ROW         = ~(ROWS'(1) << row);

    // Frame result merges the rows already seen with the row-3 sample taken this cycle.
    always_comb begin
        row_n    = (low == '0) ? 2'd0 : ((low & (low - 4'd1)) == '0) ? 2'd1 : 2'd2;
        total    = sat_add(acc_n, row_n);
        row_code = {row, col_index(low)};
        res.kind = (total == 2'd0) ? RES_NONE : (total == 2'd1) ? RES_KEY : RES_MULTI;
        res.code = (row_n == 2'd1) ? row_code : acc_code;
    end

    keypad_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .res        (res),
        .press      (press),
        .rel        (rel),
        .code       (db_code)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1    <= '1;
            col_s2    <= '1;
            div       <= '0;
            row       <= '0;
            acc_n     <= '0;
            acc_code  <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
            digits    <= '0;
        end else begin
            col_s1    <= COL;
            col_s2    <= col_s1;
            div       <= sample ? '0 : div + 1'b1;
            row       <= sample ? row + 2'd1 : row;
            if (sample) begin
                acc_n    <= (row == 2'd3) ? 2'd0 : total;
                acc_code <= (row_n == 2'd1) ? row_code : acc_code;
            end
            key_valid <= press;
            key_code  <= press ? db_code : key_code;
            key_held  <= press ? 1'b1 : rel ? 1'b0 : key_held;
            digits    <= press ? {clr ? 12'h000 : digits[11:0], db_code} : clr ? 16'h0000 : digits;
        end
    end

endmodule
